// File: rtl/gcd_ctrl_unit.sv
// GCD controller: sequences an external A/B subtract-and-swap datapath (IDLE -> CALC -> DONE).
// Optional CALC-cycle counter on calc_cycles is built when GCD_CTRL_CYCLE_CNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for an operand pair; req_rdy high
// CALC  | swap or subtract each cycle until B reaches zero
// DONE  | result held in A; resp_val high until resp_rdy
module gcd_ctrl_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_val,
  output logic             req_rdy,
  output logic             resp_val,
  input  logic             resp_rdy,
  input  logic             is_a_lt_b,
  input  logic             is_b_zero,
  output logic             a_reg_en,
  output logic             b_reg_en,
  output logic [1:0]       a_mux_sel,
  output logic             b_mux_sel
`ifdef GCD_CTRL_CYCLE_CNT_EN
  ,
  output logic [CNT_W-1:0] calc_cycles
`endif
);

  if (CNT_W < 4 || CNT_W > 32) begin : g_bad_cnt_w
    $error("gcd_ctrl_unit: CNT_W must be in 4..32");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] A_SEL_IN  = 2'd0;
  localparam logic [1:0] A_SEL_B   = 2'd1;
  localparam logic [1:0] A_SEL_SUB = 2'd2;

  state_t state, state_nxt;
  // Low from reset until the first clock edge after release, so nothing acts before then.
  logic   live;
  logic   go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  assign go = live & ~reset;

  always_comb begin
    state_nxt = state;
    req_rdy   = 1'b0;
    resp_val  = 1'b0;
    a_reg_en  = 1'b0;
    b_reg_en  = 1'b0;
    a_mux_sel = A_SEL_IN;
    b_mux_sel = 1'b0;
    case (state)
      IDLE: begin
        req_rdy = go;
        if (go && req_val) begin
          a_reg_en  = 1'b1;
          b_reg_en  = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (go) begin
          if (is_a_lt_b) begin
            a_reg_en  = 1'b1;
            b_reg_en  = 1'b1;
            a_mux_sel = A_SEL_B;
            b_mux_sel = 1'b1;
          end else if (!is_b_zero) begin
            a_reg_en  = 1'b1;
            a_mux_sel = A_SEL_SUB;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        resp_val = go;
        if (go && resp_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef GCD_CTRL_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == IDLE && go && req_val) begin
      cnt <= '0;
    end else if (state == CALC && go && cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign calc_cycles = cnt;
`endif

endmodule

// File: tb/tb_gcd_ctrl_unit.sv
// Self-checking bench for gcd_ctrl_unit with a behavioural 16-bit A/B datapath.
// Counter checks are compiled when GCD_CTRL_CYCLE_CNT_EN is defined.
module tb_gcd_ctrl_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_val = 1'b0;
  logic        req_rdy;
  logic        resp_val;
  logic        resp_rdy = 1'b0;
  logic        is_a_lt_b;
  logic        is_b_zero;
  logic        a_reg_en;
  logic        b_reg_en;
  logic [1:0]  a_mux_sel;
  logic        b_mux_sel;
`ifdef GCD_CTRL_CYCLE_CNT_EN
  logic [15:0] calc_cycles;
`endif

  logic [15:0] a_r = 16'd0;
  logic [15:0] b_r = 16'd0;
  logic [15:0] in_a = 16'd0;
  logic [15:0] in_b = 16'd0;

  int n_checks = 0;
  int n_fail   = 0;

  gcd_ctrl_unit #(.CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .is_a_lt_b (is_a_lt_b),
    .is_b_zero (is_b_zero),
    .a_reg_en  (a_reg_en),
    .b_reg_en  (b_reg_en),
    .a_mux_sel (a_mux_sel),
    .b_mux_sel (b_mux_sel)
`ifdef GCD_CTRL_CYCLE_CNT_EN
    ,
    .calc_cycles (calc_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Datapath model: enabled A/B registers with their input muxes.
  always @(posedge clk) begin
    if (a_reg_en) begin
      case (a_mux_sel)
        2'd0:    a_r <= in_a;
        2'd1:    a_r <= b_r;
        2'd2:    a_r <= a_r - b_r;
        default: a_r <= 16'hdead;
      endcase
    end
    if (b_reg_en) b_r <= b_mux_sel ? a_r : in_b;
  end

  assign is_a_lt_b = (a_r < b_r);
  assign is_b_zero = (b_r == 16'd0);

  wire [6:0] outs = {req_rdy, resp_val, a_reg_en, b_reg_en, a_mux_sel, b_mux_sel};
  wire [4:0] ctl  = {a_reg_en, b_reg_en, a_mux_sel, b_mux_sel};

  task automatic test_reset();
    req_val = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (outs !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b want 0000000", outs);
    end
`ifdef GCD_CTRL_CYCLE_CNT_EN
    n_checks++;
    if (calc_cycles !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d want 0", calc_cycles);
    end
`endif
    req_val = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: req_rdy=%b resp_val=%b want 1 0", req_rdy, resp_val);
    end
  endtask

  task automatic test_sub_sequence();
    logic [4:0] exp_ctl [5];
    exp_ctl[0] = 5'b10100;
    exp_ctl[1] = 5'b10100;
    exp_ctl[2] = 5'b10100;
    exp_ctl[3] = 5'b11011;
    exp_ctl[4] = 5'b00000;
    @(negedge clk);
    in_a = 16'd15;
    in_b = 16'd5;
    req_val = 1'b1;
    resp_rdy = 1'b1;
    #1;
    n_checks++;
    if (req_rdy !== 1'b1 || ctl !== 5'b11000) begin
      n_fail++;
      $display("FAIL accept_15_5: req_rdy=%b ctl=%b want 1 11000", req_rdy, ctl);
    end
    @(negedge clk);
    req_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (ctl !== exp_ctl[i] || req_rdy !== 1'b0 || resp_val !== 1'b0) begin
        n_fail++;
        $display("FAIL calc_15_5[%0d]: ctl=%b rdy=%b val=%b want %b 0 0",
                 i, ctl, req_rdy, resp_val, exp_ctl[i]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (resp_val !== 1'b1 || a_r !== 16'd5 || ctl !== 5'd0) begin
      n_fail++;
      $display("FAIL done_15_5: resp_val=%b A=%0d ctl=%b want 1 5 00000", resp_val, a_r, ctl);
    end
`ifdef GCD_CTRL_CYCLE_CNT_EN
    n_checks++;
    if (calc_cycles !== 16'd5) begin
      n_fail++;
      $display("FAIL cnt_15_5: got %0d want 5", calc_cycles);
    end
`endif
    @(negedge clk);
    n_checks++;
    if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_15_5: req_rdy=%b resp_val=%b want 1 0", req_rdy, resp_val);
    end
`ifdef GCD_CTRL_CYCLE_CNT_EN
    n_checks++;
    if (calc_cycles !== 16'd5) begin
      n_fail++;
      $display("FAIL cnt_hold_idle: got %0d want 5", calc_cycles);
    end
`endif
    resp_rdy = 1'b0;
  endtask

  task automatic test_swap_hold();
    int calc_n = 0;
    in_a = 16'd3;
    in_b = 16'd9;
    req_val = 1'b1;
    @(negedge clk);
    // req_val stays high through CALC and DONE; it must never be taken.
    n_checks++;
    if (ctl !== 5'b11011) begin
      n_fail++;
      $display("FAIL swap_first_3_9: ctl=%b want 11011", ctl);
    end
    while (!resp_val && calc_n < 20) begin
      n_checks++;
      if (req_rdy !== 1'b0 || (!a_reg_en && a_mux_sel !== 2'd0) ||
          (!b_reg_en && b_mux_sel !== 1'b0) || a_mux_sel === 2'd3) begin
        n_fail++;
        $display("FAIL calc_3_9[%0d]: rdy=%b ctl=%b", calc_n, req_rdy, ctl);
      end
      calc_n++;
      @(negedge clk);
    end
    n_checks++;
    if (calc_n !== 6) begin
      n_fail++;
      $display("FAIL calc_len_3_9: got %0d want 6", calc_n);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (resp_val !== 1'b1 || req_rdy !== 1'b0 || ctl !== 5'd0 || a_r !== 16'd3) begin
        n_fail++;
        $display("FAIL done_hold[%0d]: val=%b rdy=%b ctl=%b A=%0d want 1 0 00000 3",
                 i, resp_val, req_rdy, ctl, a_r);
      end
      @(negedge clk);
    end
`ifdef GCD_CTRL_CYCLE_CNT_EN
    n_checks++;
    if (calc_cycles !== 16'd6) begin
      n_fail++;
      $display("FAIL cnt_3_9: got %0d want 6", calc_cycles);
    end
`endif
    req_val = 1'b0;
    resp_rdy = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
      n_fail++;
      $display("FAIL release_3_9: req_rdy=%b resp_val=%b want 1 0", req_rdy, resp_val);
    end
    resp_rdy = 1'b0;
  endtask

  task automatic test_zero();
    in_a = 16'd0;
    in_b = 16'd0;
    req_val = 1'b1;
    @(negedge clk);
    req_val = 1'b0;
    n_checks++;
    if (outs !== 7'd0) begin
      n_fail++;
      $display("FAIL calc_0_0: outs=%b want 0000000", outs);
    end
    @(negedge clk);
    n_checks++;
    if (resp_val !== 1'b1 || a_r !== 16'd0) begin
      n_fail++;
      $display("FAIL done_0_0: resp_val=%b A=%0d want 1 0", resp_val, a_r);
    end
`ifdef GCD_CTRL_CYCLE_CNT_EN
    n_checks++;
    if (calc_cycles !== 16'd1) begin
      n_fail++;
      $display("FAIL cnt_0_0: got %0d want 1", calc_cycles);
    end
`endif
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    n_checks++;
    if (req_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_after_0_0: req_rdy=%b want 1", req_rdy);
    end
  endtask

  task automatic test_reset_mid_calc();
    in_a = 16'd15;
    in_b = 16'd5;
    req_val = 1'b1;
    @(negedge clk);
    req_val = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (outs !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_mid_calc: outs=%b want 0000000", outs);
    end
`ifdef GCD_CTRL_CYCLE_CNT_EN
    n_checks++;
    if (calc_cycles !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_cnt: got %0d want 0", calc_cycles);
    end
`endif
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (req_rdy !== 1'b1 || resp_val !== 1'b0 || ctl !== 5'd0) begin
      n_fail++;
      $display("FAIL after_mid_reset: rdy=%b val=%b ctl=%b want 1 0 00000",
               req_rdy, resp_val, ctl);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] oa [3];
    logic [15:0] ob [3];
    logic [15:0] er [3];
    int          ec [3];
    int k = 0;
    int r = 0;
    int calc_n = 0;
    int cyc = 0;
    logic prev_hs = 1'b0;
    oa[0] = 16'd15; ob[0] = 16'd5; er[0] = 16'd5; ec[0] = 5;
    oa[1] = 16'd0;  ob[1] = 16'd0; er[1] = 16'd0; ec[1] = 1;
    oa[2] = 16'd12; ob[2] = 16'd8; er[2] = 16'd4; ec[2] = 6;
    @(negedge clk);
    req_val = 1'b1;
    resp_rdy = 1'b1;
    while (r < 3 && cyc < 80) begin
      if (prev_hs) begin
        n_checks++;
        if (req_rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_rdy_after_hs[%0d]: req_rdy=%b want 1", r, req_rdy);
        end
      end
      prev_hs = 1'b0;
      if (req_rdy) begin
        if (k < 3) begin
          in_a = oa[k];
          in_b = ob[k];
          k++;
          calc_n = 0;
        end else begin
          req_val = 1'b0;
        end
      end else if (resp_val) begin
        n_checks++;
        if (a_r !== er[r] || calc_n !== ec[r]) begin
          n_fail++;
          $display("FAIL b2b_result[%0d]: A=%0d cycles=%0d want %0d %0d",
                   r, a_r, calc_n, er[r], ec[r]);
        end
`ifdef GCD_CTRL_CYCLE_CNT_EN
        n_checks++;
        if (calc_cycles !== ec[r][15:0]) begin
          n_fail++;
          $display("FAIL b2b_cnt[%0d]: got %0d want %0d", r, calc_cycles, ec[r]);
        end
`endif
        r++;
        prev_hs = 1'b1;
      end else begin
        n_checks++;
        if ((!a_reg_en && a_mux_sel !== 2'd0) || (!b_reg_en && b_mux_sel !== 1'b0)) begin
          n_fail++;
          $display("FAIL b2b_sel_zero: ctl=%b", ctl);
        end
        calc_n++;
      end
      cyc++;
      @(negedge clk);
    end
    // Stop before the next edge so no fourth operation is taken.
    req_val = 1'b0;
    n_checks++;
    if (r !== 3 || k !== 3 || req_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_totals: results=%0d accepts=%0d rdy=%b want 3 3 1", r, k, req_rdy);
    end
    @(negedge clk);
    n_checks++;
    if (req_rdy !== 1'b1 || a_reg_en !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_extra: rdy=%b a_en=%b want 1 0", req_rdy, a_reg_en);
    end
    resp_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sub_sequence();
    test_swap_hold();
    test_zero();
    test_reset_mid_calc();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
